spi_cu_burst: RTL and testbench

Parametrised SPI slave control unit that sequences command, multi-byte address and burst data phases for the register-file slave. It sits between the SPI shift register/bit counter and the register file. It decodes the command byte and assembles an address of one or more bytes. It then drives register-file writes or shift-register parallel loads for each data byte, auto-incrementing the address with wrap-around at a configurable memory depth. Everything is synchronous to one clock. An optional write-enable latch protects writes.

---
 rtl/spi_cu_burst.sv | 201 ++++++++++++++++++++
 tb/tb_spi_cu_burst.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_cu_burst.sv
// SPI slave control unit: command decode, multi-byte address assembly, burst read/write sequencing.
// Optional write-enable latch is compiled in with `SPI_CU_WEL_EN.
module spi_cu_burst #(
    parameter int DATA_WIDTH   = 8,
    parameter int ADDRESS_SIZE = 10,
    parameter int ADDR_BYTES   = 2,
    parameter int MEM_DEPTH    = 1024
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_spi_cs,
    input  logic                    byte_is_ready,
    input  logic [DATA_WIDTH-1:0]   i_recieved_byte,
    output logic [ADDRESS_SIZE-1:0] o_address,
    output logic                    o_shift_en,
    output logic                    o_shift_reg_par_load,
    output logic                    o_count_en,
    output logic                    o_count_clr,
    output logic                    o_wr_en,
    output logic                    o_err,
    output logic                    o_done
);

    localparam int FULLW = ADDR_BYTES * DATA_WIDTH;
    localparam int CW    = (ADDR_BYTES > 1) ? $clog2(ADDR_BYTES) : 1;

    localparam logic [CW-1:0]           CNT_LAST  = CW'(ADDR_BYTES - 1);
    localparam logic [FULLW:0]          DEPTH_W   = (FULLW + 1)'(MEM_DEPTH);
    localparam logic [ADDRESS_SIZE-1:0] ADDR_LAST = ADDRESS_SIZE'(MEM_DEPTH - 1);
    localparam logic [DATA_WIDTH-1:0]   CMD_WRITE = DATA_WIDTH'(8'h02);
    localparam logic [DATA_WIDTH-1:0]   CMD_READ  = DATA_WIDTH'(8'h03);
`ifdef SPI_CU_WEL_EN
    localparam logic [DATA_WIDTH-1:0]   CMD_WREN  = DATA_WIDTH'(8'h06);
    localparam logic [DATA_WIDTH-1:0]   CMD_WRDI  = DATA_WIDTH'(8'h04);
`endif

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        DATA,
        IGNORE
    } state_t;

    state_t                 state_q, state_d;
    logic [FULLW-1:0]       addr_q, addr_d;
    logic [DATA_WIDTH-1:0]  cmd_q, cmd_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   err_q, err_d;
`ifdef SPI_CU_WEL_EN
    logic                   wel_q, wel_d;
    logic                   wrote_q, wrote_d;
`endif

    logic [FULLW-1:0]        addr_asm;
    logic                    asm_in_range;
    logic [ADDRESS_SIZE-1:0] addr_cur;
    logic [ADDRESS_SIZE-1:0] addr_next;
    logic [ADDRESS_SIZE-1:0] addr_out;
    logic                    wr_strobe;
    logic                    pl_strobe;

    // Range check uses the full assembled value so dropped upper bits still flag an error.
    assign addr_asm     = (addr_q << DATA_WIDTH) | FULLW'(i_recieved_byte);
    assign asm_in_range = ({1'b0, addr_asm} < DEPTH_W);
    assign addr_cur     = addr_q[ADDRESS_SIZE-1:0];
    assign addr_next    = (addr_cur == ADDR_LAST) ? '0 : addr_cur + 1'b1;

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            cmd_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
`ifdef SPI_CU_WEL_EN
            wel_q   <= 1'b0;
            wrote_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cmd_q   <= cmd_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
`ifdef SPI_CU_WEL_EN
            wel_q   <= wel_d;
            wrote_q <= wrote_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        cmd_d     = cmd_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
`ifdef SPI_CU_WEL_EN
        wel_d     = wel_q;
        wrote_d   = wrote_q;
`endif
        wr_strobe = 1'b0;
        pl_strobe = 1'b0;
        addr_out  = addr_cur;

        if (i_spi_cs) begin
            state_d = IDLE;
`ifdef SPI_CU_WEL_EN
            if (wrote_q) begin
                wel_d   = 1'b0;
                wrote_d = 1'b0;
            end
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = CMD;
                    err_d   = 1'b0;
`ifdef SPI_CU_WEL_EN
                    wrote_d = 1'b0;
`endif
                end
                CMD: begin
                    if (byte_is_ready) begin
                        cmd_d = i_recieved_byte;
                        if (i_recieved_byte == CMD_WRITE || i_recieved_byte == CMD_READ) begin
                            state_d = ADDR;
                            cnt_d   = '0;
                            addr_d  = '0;
`ifdef SPI_CU_WEL_EN
                        end else if (i_recieved_byte == CMD_WREN) begin
                            state_d = IGNORE;
                            wel_d   = 1'b1;
                        end else if (i_recieved_byte == CMD_WRDI) begin
                            state_d = IGNORE;
                            wel_d   = 1'b0;
`endif
                        end else begin
                            state_d = IGNORE;
                            err_d   = 1'b1;
                        end
                    end
                end
                ADDR: begin
                    if (byte_is_ready) begin
                        addr_d = addr_asm;
                        if (cnt_q == CNT_LAST) begin
                            if (!asm_in_range) begin
                                state_d = IGNORE;
                                err_d   = 1'b1;
                            end else begin
                                state_d = DATA;
                                if (cmd_q == CMD_READ) begin
                                    pl_strobe = 1'b1;
                                    addr_out  = addr_asm[ADDRESS_SIZE-1:0];
                                end
                            end
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                DATA: begin
                    if (byte_is_ready) begin
                        if (cmd_q == CMD_WRITE) begin
`ifdef SPI_CU_WEL_EN
                            if (!wel_q) begin
                                err_d = 1'b1;
                            end else begin
                                wr_strobe = 1'b1;
                                addr_d    = FULLW'(addr_next);
                                wrote_d   = 1'b1;
                            end
`else
                            wr_strobe = 1'b1;
                            addr_d    = FULLW'(addr_next);
`endif
                        end else begin
                            // Read prefetches the following word; the first was loaded on the last address byte.
                            pl_strobe = 1'b1;
                            addr_out  = addr_next;
                            addr_d    = FULLW'(addr_next);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_done               = i_spi_cs;
    assign o_shift_en           = i_rst & ~i_spi_cs;
    assign o_count_en           = i_rst & ~i_spi_cs;
    assign o_count_clr          = ~i_rst | (state_q == IDLE);
    assign o_wr_en              = i_rst & wr_strobe;
    assign o_shift_reg_par_load = i_rst & pl_strobe;
    assign o_err                = i_rst & err_q;
    assign o_address            = i_rst ? addr_out : '0;

endmodule

// File: tb/tb_spi_cu_burst.sv
// Scoreboard bench for spi_cu_burst: stimulus queues expected strobes, a negedge monitor checks them.
module tb_spi_cu_burst;

    logic       clk;
    logic       rst;
    logic       cs;
    logic       rdy;
    logic [7:0] din;
    logic [9:0] o_address;
    logic       o_shift_en;
    logic       o_pl;
    logic       o_count_en;
    logic       o_count_clr;
    logic       o_wr_en;
    logic       o_err;
    logic       o_done;

    typedef struct packed {
        logic       is_wr;
        logic [9:0] addr;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    spi_cu_burst #(
        .DATA_WIDTH  (8),
        .ADDRESS_SIZE(10),
        .ADDR_BYTES  (2),
        .MEM_DEPTH   (1024)
    ) dut (
        .i_clk               (clk),
        .i_rst               (rst),
        .i_spi_cs            (cs),
        .byte_is_ready       (rdy),
        .i_recieved_byte     (din),
        .o_address           (o_address),
        .o_shift_en          (o_shift_en),
        .o_shift_reg_par_load(o_pl),
        .o_count_en          (o_count_en),
        .o_count_clr         (o_count_clr),
        .o_wr_en             (o_wr_en),
        .o_err               (o_err),
        .o_done              (o_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (o_wr_en || o_pl) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_strobe: got wr=%0b pl=%0b addr=%0h, expected no strobe",
                         o_wr_en, o_pl, o_address);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("strobe_kind", {30'd0, o_wr_en, o_pl}, e.is_wr ? 32'd2 : 32'd1);
                chk("strobe_addr", {22'd0, o_address}, {22'd0, e.addr});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rdy = 1'b1;
        din = b;
        step();
        rdy = 1'b0;
    endtask

    task automatic cs_low();
        cs = 1'b0;
        step();
    endtask

    task automatic cs_high();
        cs = 1'b1;
        step();
    endtask

    task automatic push(input logic w, input logic [9:0] a);
        exp_t e;
        e.is_wr = w;
        e.addr  = a;
        q.push_back(e);
    endtask

    task automatic wren();
`ifdef SPI_CU_WEL_EN
        cs_low();
        send_byte(8'h06);
        cs_high();
`endif
    endtask

    initial begin
        rst = 1'b0;
        cs  = 1'b1;
        rdy = 1'b0;
        din = '0;
        step();
        step();
        chk("rst_count_clr", {31'd0, o_count_clr}, 32'd1);
        chk("rst_wr_en",     {31'd0, o_wr_en},     32'd0);
        chk("rst_shift_en",  {31'd0, o_shift_en},  32'd0);
        chk("rst_err",       {31'd0, o_err},       32'd0);
        chk("rst_address",   {22'd0, o_address},   32'd0);
        chk("rst_done",      {31'd0, o_done},      32'd1);
        rst = 1'b1;
        step();
        chk("idle_count_clr", {31'd0, o_count_clr}, 32'd1);

        // Write burst, back-to-back data bytes
        wren();
        push(1'b1, 10'h010);
        push(1'b1, 10'h011);
        push(1'b1, 10'h012);
        cs_low();
        chk("cs_shift_en", {31'd0, o_shift_en}, 32'd1);
        chk("cs_done",     {31'd0, o_done},     32'd0);
        send_byte(8'h02); send_byte(8'h00); send_byte(8'h10);
        send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC);
        chk("wr_addr_after", {22'd0, o_address}, 32'h013);
        chk("wr_err", {31'd0, o_err}, 32'd0);
        cs_high();
        chk("wr_idle", {31'd0, o_count_clr}, 32'd1);

        // Read burst
        push(1'b0, 10'h005);
        push(1'b0, 10'h006);
        push(1'b0, 10'h007);
        cs_low();
        send_byte(8'h03); send_byte(8'h00); send_byte(8'h05);
        send_byte(8'h11); send_byte(8'h22);
        cs_high();

        // Wrap at MEM_DEPTH
        wren();
        push(1'b1, 10'd1022);
        push(1'b1, 10'd1023);
        push(1'b1, 10'd0);
        cs_low();
        send_byte(8'h02); send_byte(8'h03); send_byte(8'hFE);
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
        chk("wrap_addr_after", {22'd0, o_address}, 32'd1);
        cs_high();

        // Bad command
        cs_low();
        send_byte(8'h7E);
        chk("badcmd_err", {31'd0, o_err}, 32'd1);
        send_byte(8'h02); send_byte(8'h00); send_byte(8'h00);
        cs_high();
        chk("badcmd_err_sticky", {31'd0, o_err}, 32'd1);

        // Out-of-range address
        wren();
        cs_low();
        chk("err_cleared_on_start", {31'd0, o_err}, 32'd0);
        send_byte(8'h02); send_byte(8'h04); send_byte(8'h00);
        send_byte(8'hAA);
        chk("range_err", {31'd0, o_err}, 32'd1);
        cs_high();

        // Clean transaction after errors
        wren();
        push(1'b1, 10'h020);
        cs_low();
        send_byte(8'h02); send_byte(8'h00); send_byte(8'h20); send_byte(8'h55);
        chk("clean_err", {31'd0, o_err}, 32'd0);
        cs_high();

        // Abort: CS rises with the 2nd data byte
        wren();
        push(1'b1, 10'h030);
        cs_low();
        send_byte(8'h02); send_byte(8'h00); send_byte(8'h30); send_byte(8'h11);
        cs  = 1'b1;
        rdy = 1'b1;
        din = 8'h22;
        step();
        rdy = 1'b0;
        chk("abort_idle", {31'd0, o_count_clr}, 32'd1);

        // Mid-burst reset, with byte_is_ready asserted during reset
        wren();
        push(1'b1, 10'h040);
        cs_low();
        send_byte(8'h02); send_byte(8'h00); send_byte(8'h40); send_byte(8'h77);
        rst = 1'b0;
        rdy = 1'b1;
        din = 8'h99;
        step();
        rdy = 1'b0;
        chk("midrst_count_clr", {31'd0, o_count_clr}, 32'd1);
        chk("midrst_address",   {22'd0, o_address},   32'd0);
        chk("midrst_shift_en",  {31'd0, o_shift_en},  32'd0);
        cs  = 1'b1;
        rst = 1'b1;
        step();
        chk("midrst_addr_reg", {22'd0, o_address},   32'd0);
        chk("midrst_idle",     {31'd0, o_count_clr}, 32'd1);

        // Error flag cleared by reset
        cs_low();
        send_byte(8'h7E);
        rst = 1'b0;
        step();
        cs  = 1'b1;
        rst = 1'b1;
        step();
        chk("rst_clears_err", {31'd0, o_err}, 32'd0);

`ifdef SPI_CU_WEL_EN
        cs_low();
        send_byte(8'h02); send_byte(8'h00); send_byte(8'h50); send_byte(8'hAA);
        chk("wel_block_err", {31'd0, o_err}, 32'd1);
        cs_high();
        wren();
        push(1'b1, 10'h051);
        cs_low();
        send_byte(8'h02); send_byte(8'h00); send_byte(8'h51); send_byte(8'hBB);
        chk("wel_ok_err", {31'd0, o_err}, 32'd0);
        cs_high();
        cs_low();
        send_byte(8'h02); send_byte(8'h00); send_byte(8'h52); send_byte(8'hCC);
        chk("wel_autoclr_err", {31'd0, o_err}, 32'd1);
        cs_high();
`endif

        step();
        step();
        chk("scoreboard_drained", q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
